// File: rtl/chunked_adder_pkg.sv
// ---------------------------------------------------------------------------
// chunked_adder_pkg
//   Shared types and helpers for the chunked (multi-cycle) adder.
//   - state_t   : controller states IDLE / RUN / DONE
//   - idxWidth  : number of bits needed to index n items (at least 1)
//   Optional feature macro used by the files importing this package:
//   CHUNKED_ADDER_SUB_EN (adds subtract support).
// ---------------------------------------------------------------------------
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A counter or select for n items needs clog2(n) bits, but never fewer
    // than one so that the degenerate single-item case still has a signal.
    function automatic int idxWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// ---------------------------------------------------------------------------
// chunked_adder_if
//   Valid/ready operand and result bundle for chunked_adder.
//   Parameter: WIDTH (operand/sum width).
//   Signals:
//     in_valid, a, b, cin, (sub)  producer -> adder
//     in_ready                    adder -> producer
//     out_valid, sum, cout, overflow  adder -> consumer
//     out_ready                   consumer -> adder
//   The sub signal only exists when CHUNKED_ADDER_SUB_EN is defined.
//   Modports: master (drives operands, consumes results), slave (the adder).
// ---------------------------------------------------------------------------
interface chunked_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CHUNKED_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
`ifdef CHUNKED_ADDER_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
`ifdef CHUNKED_ADDER_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );

endinterface

// File: rtl/chunked_adder_add_slice.sv
// ---------------------------------------------------------------------------
// chunked_adder_add_slice
//   Purely combinational CHUNK-bit ripple-carry slice built from full-add
//   cells. One instance is reused every cycle by chunked_adder.
//   Parameter: CHUNK (slice width).
//   Ports:
//     a_i, b_i  in   CHUNK  slice operands
//     c_i       in   1      carry into bit 0
//     sum_o     out  CHUNK  slice sum
//     cout_o    out  1      carry out of the slice MSB
//     cmsb_o    out  1      carry into the slice MSB (signed-overflow term)
// ---------------------------------------------------------------------------
module chunked_adder_add_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] carry;

    // Ripple the carry from bit 0 upwards; carry[i] is the carry into bit i,
    // so carry[CHUNK] leaves the slice and carry[CHUNK-1] enters its MSB.
    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = c_i;
        for (int i = 0; i < CHUNK; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = carry[CHUNK];
    assign cmsb_o = carry[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// ---------------------------------------------------------------------------
// chunked_adder
//   Multi-cycle adder: adds two WIDTH-bit operands CHUNK bits per clock
//   through a single CHUNK-bit ripple slice, registering the carry between
//   slices. Valid/ready handshakes on both the operand and result sides.
//   Parameters: WIDTH (operand width), CHUNK (bits per cycle, divides WIDTH).
//   Ports:
//     clk    in   1   rising-edge clock
//     rst_n  in   1   asynchronous active-low reset
//     bus    slave modport of chunked_adder_if (operands, results, handshakes)
//   Macro CHUNKED_ADDER_SUB_EN: when defined, bus.sub selects a - b
//   (slices see ~b and the initial carry is forced to 1, cin ignored).
// ---------------------------------------------------------------------------
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    chunked_adder_if.slave  bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idxWidth(NCHUNK);
    localparam int BASEW  = idxWidth(WIDTH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_badChunk
        $error("chunked_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [BASEW-1:0] sliceBase;
    logic [CHUNK-1:0] sliceSum;
    logic             sliceCout;
    logic             sliceCmsb;

    // Bit offset of the slice currently being added.
    assign sliceBase = BASEW'(int'(idx_q) * CHUNK);

    chunked_adder_add_slice #(
        .CHUNK (CHUNK)
    ) u_addSlice (
        .a_i    (opA_q[sliceBase +: CHUNK]),
        .b_i    (opB_q[sliceBase +: CHUNK]),
        .c_i    (carry_q),
        .sum_o  (sliceSum),
        .cout_o (sliceCout),
        .cmsb_o (sliceCmsb)
    );

    // All state lives here; reset drops any in-flight operation and clears
    // the visible result so the consumer never sees stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Controller: IDLE captures operands (with b already inverted for a
    // subtract so RUN never needs to know the operation), RUN walks the
    // slices LSB first, DONE holds the result until the consumer takes it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    opA_d   = bus.a;
`ifdef CHUNKED_ADDER_SUB_EN
                    opB_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
`else
                    opB_d   = bus.b;
                    carry_d = bus.cin;
`endif
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[sliceBase +: CHUNK] = sliceSum;
                carry_d = sliceCout;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = sliceCout;
                    ovf_d   = sliceCout ^ sliceCmsb;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;

endmodule
